branch_exec_unit: RTL and testbench

- Execution stage directly downstream of the branch reservation station. It accepts one operand-complete conditional branch per cycle.
- It evaluates the condition and computes the resolved next PC and the misprediction flag.
- Results are held in a small output queue until the common data bus arbiter grants a broadcast slot to the reorder buffer.
- A reorder-buffer flush discards all in-flight branches.

---
 rtl/branch_exec_unit_if.sv | 38 +++
 rtl/branch_exec_unit.sv | 132 +++++++++++++
 tb/tb_branch_exec_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_exec_unit_if.sv
// Issue and result channel bundle for the branch execution unit.
interface branch_exec_unit_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
);
    logic              issue_valid;
    logic              issue_ready;
    logic [TAG_W-1:0]  issue_rob;
    logic [2:0]        issue_subtype;
    logic [DATA_W-1:0] issue_src1;
    logic [DATA_W-1:0] issue_src2;
    logic [DATA_W-1:0] issue_pc;
    logic [DATA_W-1:0] issue_imm;
    logic              issue_pred_taken;

    logic              result_valid;
    logic [TAG_W-1:0]  result_rob;
    logic              result_taken;
    logic [DATA_W-1:0] result_next_pc;
    logic              result_mispredict;
    logic              result_grant;

    // Environment side: reservation station plus CDB arbiter.
    modport master (
        output issue_valid, issue_rob, issue_subtype, issue_src1, issue_src2,
               issue_pc, issue_imm, issue_pred_taken, result_grant,
        input  issue_ready, result_valid, result_rob, result_taken,
               result_next_pc, result_mispredict
    );

    // Execution unit side.
    modport slave (
        input  issue_valid, issue_rob, issue_subtype, issue_src1, issue_src2,
               issue_pc, issue_imm, issue_pred_taken, result_grant,
        output issue_ready, result_valid, result_rob, result_taken,
               result_next_pc, result_mispredict
    );
endinterface

// File: rtl/branch_exec_unit.sv
// Branch execution unit: one-cycle condition evaluation stage (E1) feeding a
// small FIFO that holds resolved branches until the CDB grants a broadcast.
module branch_exec_unit #(
    parameter int               DATA_W      = 32,
    parameter int               TAG_W       = 6,
    parameter logic [TAG_W-1:0] INVALID_TAG = 6'b010000,
    parameter int               QDEPTH      = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    output logic [1:0]          inflight,
    branch_exec_unit_if.slave   bus
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    // E1 stage registers
    logic              e1_valid;
    logic [TAG_W-1:0]  e1_rob;
    logic              e1_taken;
    logic [DATA_W-1:0] e1_next_pc;
    logic              e1_mispredict;

    // Output queue storage and bookkeeping
    logic [TAG_W-1:0]  q_rob        [QDEPTH];
    logic              q_taken      [QDEPTH];
    logic [DATA_W-1:0] q_next_pc    [QDEPTH];
    logic              q_mispredict [QDEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     q_count;

    logic              taken_c;
    logic [DATA_W-1:0] next_pc_c;
    logic [CW-1:0]     occupancy;
    logic              accept;
    logic              push;
    logic              pop;

    assign occupancy     = q_count + CW'(e1_valid);
    // No credit for a same-cycle pop; held low while reset is asserted.
    assign bus.issue_ready = reset && (occupancy < CW'(QDEPTH));
    assign accept        = bus.issue_valid && bus.issue_ready && !flush;
    assign push          = e1_valid;
    assign pop           = (q_count != '0) && bus.result_grant;
    assign inflight      = 2'(occupancy);

    // Condition evaluation and target selection from the issue operands.
    always_comb begin
        taken_c = 1'b0;
        unique case (bus.issue_subtype)
            3'b000:  taken_c = (bus.issue_src1 == bus.issue_src2);
            3'b001:  taken_c = (bus.issue_src1 != bus.issue_src2);
            3'b100:  taken_c = ($signed(bus.issue_src1) <  $signed(bus.issue_src2));
            3'b101:  taken_c = ($signed(bus.issue_src1) >= $signed(bus.issue_src2));
            3'b110:  taken_c = (bus.issue_src1 <  bus.issue_src2);
            3'b111:  taken_c = (bus.issue_src1 >= bus.issue_src2);
            default: taken_c = 1'b0;
        endcase
        next_pc_c = taken_c ? (bus.issue_pc + bus.issue_imm)
                            : (bus.issue_pc + DATA_W'(4));
    end

    // E1 stage: capture the resolved branch; flush drops it and any same-cycle issue.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            e1_valid      <= 1'b0;
            e1_rob        <= '0;
            e1_taken      <= 1'b0;
            e1_next_pc    <= '0;
            e1_mispredict <= 1'b0;
        end else if (flush) begin
            e1_valid      <= 1'b0;
        end else begin
            e1_valid <= accept;
            if (accept) begin
                e1_rob        <= bus.issue_rob;
                e1_taken      <= taken_c;
                e1_next_pc    <= next_pc_c;
                e1_mispredict <= taken_c ^ bus.issue_pred_taken;
            end
        end
    end

    // Queue payload write; contents are only observed while counted as valid.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            q_rob[wr_ptr]        <= e1_rob;
            q_taken[wr_ptr]      <= e1_taken;
            q_next_pc[wr_ptr]    <= e1_next_pc;
            q_mispredict[wr_ptr] <= e1_mispredict;
        end
    end

    // Queue pointers and occupancy count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   q_count <= q_count + CW'(1);
                2'b01:   q_count <= q_count - CW'(1);
                default: q_count <= q_count;
            endcase
        end
    end

    // Head-of-queue presentation; idle values when empty.
    always_comb begin
        bus.result_valid      = 1'b0;
        bus.result_rob        = INVALID_TAG;
        bus.result_taken      = 1'b0;
        bus.result_next_pc    = '0;
        bus.result_mispredict = 1'b0;
        if (q_count != '0) begin
            bus.result_valid      = 1'b1;
            bus.result_rob        = q_rob[rd_ptr];
            bus.result_taken      = q_taken[rd_ptr];
            bus.result_next_pc    = q_next_pc[rd_ptr];
            bus.result_mispredict = q_mispredict[rd_ptr];
        end
    end
endmodule

// File: tb/tb_branch_exec_unit.sv
// Scoreboard bench for branch_exec_unit: directed issues push expected results,
// a monitor pops and compares on every broadcast.
module tb_branch_exec_unit;
    localparam logic [5:0] INV = 6'b010000;

    typedef struct packed {
        logic [5:0]  rob;
        logic        taken;
        logic [31:0] npc;
        logic        mis;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       flush;
    logic [1:0] inflight;
    int         checks;
    int         errors;
    exp_t       exp_q[$];

    branch_exec_unit_if #(.DATA_W(32), .TAG_W(6)) ifc ();

    branch_exec_unit #(
        .DATA_W(32), .TAG_W(6), .INVALID_TAG(INV), .QDEPTH(2)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .inflight(inflight), .bus(ifc.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next edge whenever valid and grant are both high.
    always @(negedge clock) begin
        if (reset && !flush && ifc.result_valid && ifc.result_grant) begin
            exp_t act;
            act = '{ifc.result_rob, ifc.result_taken, ifc.result_next_pc, ifc.result_mispredict};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h expected none", act);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", 64'(act), 64'(e));
            end
        end
    end

    task automatic issue(input logic [5:0] rob, input logic [2:0] sub,
                         input logic [31:0] s1, input logic [31:0] s2,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic pred, input logic exp_taken,
                         input logic [31:0] exp_npc);
        bit ok;
        ifc.issue_valid      = 1'b1;
        ifc.issue_rob        = rob;
        ifc.issue_subtype    = sub;
        ifc.issue_src1       = s1;
        ifc.issue_src2       = s2;
        ifc.issue_pc         = pc;
        ifc.issue_imm        = imm;
        ifc.issue_pred_taken = pred;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (ifc.issue_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("issue_ready_timeout", 64'(0), 64'(1));
            ifc.issue_valid = 1'b0;
            return;
        end
        @(posedge clock);
        if (!flush) exp_q.push_back('{rob, exp_taken, exp_npc, exp_taken ^ pred});
        #1;
        ifc.issue_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 64'(exp_q.size()), 64'(0));
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        flush = 1'b0;
        ifc.issue_valid = 1'b0;
        ifc.issue_rob = '0;
        ifc.issue_subtype = '0;
        ifc.issue_src1 = '0;
        ifc.issue_src2 = '0;
        ifc.issue_pc = '0;
        ifc.issue_imm = '0;
        ifc.issue_pred_taken = 1'b0;
        ifc.result_grant = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_valid", 64'(ifc.result_valid), 64'(0));
        check("rst_rob", 64'(ifc.result_rob), 64'(INV));
        check("rst_fields", {ifc.result_taken, ifc.result_next_pc, ifc.result_mispredict}, 64'(0));
        check("rst_inflight", 64'(inflight), 64'(0));
        check("rst_ready", 64'(ifc.issue_ready), 64'(0));
        @(posedge clock); #1;
        reset = 1'b1;

        // Latency: BNE equal operands, predicted taken
        ifc.result_grant = 1'b1;
        issue(6'd5, 3'b001, 32'd3, 32'd3, 32'h100, 32'h20, 1'b1, 1'b0, 32'h104);
        check("lat_e1_valid", 64'(ifc.result_valid), 64'(0));
        check("lat_e1_inflight", 64'(inflight), 64'(1));
        @(posedge clock); #1;
        check("lat_q_valid", 64'(ifc.result_valid), 64'(1));
        check("lat_q_rob", 64'(ifc.result_rob), 64'(5));
        drain();

        // Condition code patterns
        issue(6'd6,  3'b100, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 1'b1, 1'b1, 32'h240);
        issue(6'd7,  3'b110, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 1'b1, 1'b0, 32'h204);
        issue(6'd8,  3'b101, 32'd5, 32'hFFFFFFFD, 32'h300, 32'hFFFFFFF0, 1'b0, 1'b1, 32'h2F0);
        issue(6'd9,  3'b111, 32'd5, 32'hFFFFFFFD, 32'h300, 32'hFFFFFFF0, 1'b0, 1'b0, 32'h304);
        issue(6'd10, 3'b010, 32'd9, 32'd9, 32'h600, 32'h80, 1'b1, 1'b0, 32'h604);
        issue(6'd11, 3'b000, 32'd1, 32'd2, 32'h700, 32'h80, 1'b0, 1'b0, 32'h704);
        drain();

        // Backpressure and FIFO order
        ifc.result_grant = 1'b0;
        issue(6'd1, 3'b000, 32'd4, 32'd4, 32'h1000, 32'h10, 1'b0, 1'b1, 32'h1010);
        issue(6'd2, 3'b001, 32'd4, 32'd4, 32'h1004, 32'h10, 1'b0, 1'b0, 32'h1008);
        ifc.issue_valid = 1'b1;
        ifc.issue_rob   = 6'd3;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("bp_ready", 64'(ifc.issue_ready), 64'(0));
            check("bp_inflight", 64'(inflight), 64'(2));
        end
        @(posedge clock); #1;
        ifc.result_grant = 1'b1;
        issue(6'd3, 3'b110, 32'd1, 32'd2, 32'h1008, 32'h100, 1'b1, 1'b1, 32'h1108);
        drain();

        // PC wrap-around
        issue(6'd12, 3'b000, 32'hAAAA5555, 32'hAAAA5555, 32'hFFFFFFF0, 32'h20, 1'b1, 1'b1, 32'h10);
        drain();

        // Flush with two held entries and a simultaneous issue
        ifc.result_grant = 1'b0;
        issue(6'd20, 3'b000, 32'd0, 32'd0, 32'h2000, 32'h8, 1'b1, 1'b1, 32'h2008);
        issue(6'd21, 3'b000, 32'd0, 32'd0, 32'h2004, 32'h8, 1'b1, 1'b1, 32'h200C);
        @(posedge clock); #1;
        check("fl_inflight_pre", 64'(inflight), 64'(2));
        flush = 1'b1;
        ifc.issue_valid = 1'b1;
        ifc.issue_rob = 6'd22;
        ifc.result_grant = 1'b1;
        @(posedge clock);
        exp_q.delete();
        #1;
        flush = 1'b0;
        ifc.issue_valid = 1'b0;
        check("fl_valid", 64'(ifc.result_valid), 64'(0));
        check("fl_inflight", 64'(inflight), 64'(0));
        check("fl_rob", 64'(ifc.result_rob), 64'(INV));
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("fl_no_result", 64'(ifc.result_valid), 64'(0));
        end
        @(posedge clock); #1;

        // Asynchronous reset while a result is held
        ifc.result_grant = 1'b0;
        issue(6'd30, 3'b001, 32'd1, 32'd2, 32'h400, 32'h8, 1'b0, 1'b1, 32'h408);
        @(posedge clock); #1;
        check("ar_valid_pre", 64'(ifc.result_valid), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        exp_q.delete();
        check("ar_valid", 64'(ifc.result_valid), 64'(0));
        check("ar_rob", 64'(ifc.result_rob), 64'(INV));
        check("ar_npc", 64'(ifc.result_next_pc), 64'(0));
        check("ar_inflight", 64'(inflight), 64'(0));
        check("ar_ready", 64'(ifc.issue_ready), 64'(0));
        @(posedge clock); #1;
        reset = 1'b1;
        ifc.result_grant = 1'b1;
        issue(6'd31, 3'b111, 32'd7, 32'd7, 32'h500, 32'h10, 1'b1, 1'b1, 32'h510);
        drain();

        check("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
